// File: rtl/prod_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module   : prod_bcd_conv
// Purpose  : Sequential binary-to-BCD converter (iterative shift-add-3,
//            "double dabble") placed after the 4x4 multiplier.
//            It captures the product on a start strobe and presents
//            registered decimal digits to the seven-segment driver.
// Ports    : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset
//            start  - conversion request, accepted only while idle
//            bin    - unsigned binary input, sampled on the accept edge
//            busy   - conversion in progress
//            done   - one-cycle pulse when bcd is updated
//            bcd    - packed digits, [3:0]=ones, [7:4]=tens, [11:8]=hundreds
//            blank  - leading-zero mask (only with PROD_BCD_BLANK_EN)
// Options  : `define PROD_BCD_BLANK_EN adds the registered blank output.
// Revision : 1.0 - initial release
// ============================================================================
module prod_bcd_conv #(
    parameter int IN_W       = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [IN_W-1:0]         bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
`ifdef PROD_BCD_BLANK_EN
    ,
    output logic [BCD_DIGITS-1:0]   blank
`endif
);

    localparam int                 C_BCD_W = 4 * BCD_DIGITS;
    localparam int                 C_CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(IN_W - 1);

    // Enough digits must exist to hold 2^IN_W-1 in decimal; the shift logic
    // also needs at least two input bits.
    generate
        if ((BCD_DIGITS * 4 < IN_W + (IN_W + 2) / 3) || (IN_W < 2)) begin : g_bad_params
            $error("prod_bcd_conv: illegal IN_W/BCD_DIGITS combination");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t               state_q,   state_d;
    logic [IN_W-1:0]      binreg_q,  binreg_d;
    logic [C_BCD_W-1:0]   scratch_q, scratch_d;
    logic [C_CNT_W-1:0]   count_q,   count_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;
    logic [C_BCD_W-1:0]   bcd_q,     bcd_d;

    logic [C_BCD_W-1:0]   adj_scratch;
    logic [C_BCD_W-1:0]   shift_scratch;
    logic [IN_W-1:0]      shift_bin;

    // Add-3 correction per digit; each digit is handled independently so no
    // carry can ripple into the next digit.
    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit_adj
            assign adj_scratch[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5)
                                          ? scratch_q[4*gi +: 4] + 4'd3
                                          : scratch_q[4*gi +: 4];
        end
    endgenerate

    // One step of the combined {scratch, binreg} left shift.
    assign shift_scratch = {adj_scratch[C_BCD_W-2:0], binreg_q[IN_W-1]};
    assign shift_bin     = {binreg_q[IN_W-2:0], 1'b0};

`ifdef PROD_BCD_BLANK_EN
    logic [BCD_DIGITS-1:0] blank_q, blank_d;
    logic [BCD_DIGITS-1:0] blank_calc;

    // Digit i is blanked only when it and every digit above it are zero.
    // The ones digit is never blanked so a zero result still shows "0".
    always_comb begin
        logic higher_zero;
        blank_calc  = '0;
        higher_zero = 1'b1;
        for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
            higher_zero   = higher_zero & (shift_scratch[4*i +: 4] == 4'd0);
            blank_calc[i] = higher_zero;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        binreg_d  = binreg_q;
        scratch_d = scratch_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
`ifdef PROD_BCD_BLANK_EN
        blank_d   = blank_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    binreg_d  = bin;
                    scratch_d = '0;
                    count_d   = '0;
                    busy_d    = 1'b1;
                    state_d   = CONV;
                end
            end
            CONV: begin
                scratch_d = shift_scratch;
                binreg_d  = shift_bin;
                count_d   = count_q + 1'b1;
                if (count_q == C_LAST) begin
                    // Only the finished value reaches bcd; intermediate
                    // scratch contents are never exposed.
                    bcd_d   = shift_scratch;
`ifdef PROD_BCD_BLANK_EN
                    blank_d = blank_calc;
`endif
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            binreg_q  <= '0;
            scratch_q <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
`ifdef PROD_BCD_BLANK_EN
            blank_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            binreg_q  <= binreg_d;
            scratch_q <= scratch_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
`ifdef PROD_BCD_BLANK_EN
            blank_q   <= blank_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
`ifdef PROD_BCD_BLANK_EN
    assign blank = blank_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prod_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module   : tb_prod_bcd_conv
// Purpose  : Self-checking bench for prod_bcd_conv: vector table, random
//            values against a decimal reference model, and hand-written
//            handshake / reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prod_bcd_conv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  bin;
    wire         busy;
    wire         done;
    wire  [11:0] bcd;
`ifdef PROD_BCD_BLANK_EN
    wire  [2:0]  blank;
`endif

    always #5 clk = ~clk;

    prod_bcd_conv #(
        .IN_W       (8),
        .BCD_DIGITS (3)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
`ifdef PROD_BCD_BLANK_EN
        ,
        .blank (blank)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: decimal digits by plain division.
    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [2:0] ref_blank(input int v);
        logic [2:0] b;
        b[0] = 1'b0;
        b[1] = (v < 10);
        b[2] = (v < 100);
        return b;
    endfunction

    // One full conversion with timing checks. Inputs driven and outputs
    // sampled on the falling edge.
    task automatic run_conv(input logic [7:0] b, input string nm);
        int  lat;
        int  busy_cyc;
        bit  seen;
        lat      = 0;
        busy_cyc = 0;
        seen     = 0;
        @(negedge clk);
        start = 1'b1;
        bin   = b;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                bin   = ~b;            // must not affect the result
            end
            if (busy) busy_cyc++;
            if (done) begin
                seen = 1;
                lat  = i;
            end
        end
        chk({nm, "_latency"}, lat, 9);
        chk({nm, "_busy_cycles"}, busy_cyc, 8);
        chk({nm, "_bcd"}, bcd, ref_bcd(int'(b)));
`ifdef PROD_BCD_BLANK_EN
        chk({nm, "_blank"}, blank, ref_blank(int'(b)));
`endif
        @(negedge clk);
        chk({nm, "_done_width"}, done, 0);
    endtask

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
        logic [2:0]  blank;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int         nd;
        int         first_at;
        logic [11:0] cap;
        int         t_at [2];
        logic [11:0] t_bcd [2];

        tbl[0] = '{8'd0,   12'h000, 3'b110};
        tbl[1] = '{8'd225, 12'h225, 3'b000};
        tbl[2] = '{8'd255, 12'h255, 3'b000};
        tbl[3] = '{8'd99,  12'h099, 3'b100};
        tbl[4] = '{8'd10,  12'h010, 3'b100};
        tbl[5] = '{8'd7,   12'h007, 3'b110};
        tbl[6] = '{8'd56,  12'h056, 3'b100};
        tbl[7] = '{8'd105, 12'h105, 3'b000};
        tbl[8] = '{8'd123, 12'h123, 3'b000};

        rst_n = 1'b0;
        start = 1'b0;
        bin   = 8'd0;
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_bcd",  bcd,  0);
`ifdef PROD_BCD_BLANK_EN
        chk("reset_blank", blank, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors (expected values also cross-checked against the model).
        for (int k = 0; k < 9; k++) begin
            chk("table_model", ref_bcd(int'(tbl[k].bin)), tbl[k].bcd);
            run_conv(tbl[k].bin, $sformatf("tbl%0d", k));
            chk($sformatf("tbl%0d_const", k), bcd, tbl[k].bcd);
`ifdef PROD_BCD_BLANK_EN
            chk($sformatf("tbl%0d_blank_const", k), blank, tbl[k].blank);
`endif
        end

        // Random values against the model.
        for (int k = 0; k < 40; k++) begin
            run_conv(8'($urandom_range(0, 255)), $sformatf("rnd%0d", k));
        end

        // Start while busy is ignored; bin changes mid-conversion are harmless.
        nd       = 0;
        first_at = 0;
        cap      = '0;
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd42;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                if (nd == 1) begin
                    first_at = c;
                    cap      = bcd;
                end
            end
            start = (c == 3);
            if (c == 3) bin = 8'd200;
            if (c == 6) bin = 8'd77;
        end
        chk("ignore_done_count", nd, 1);
        chk("ignore_done_time", first_at, 9);
        chk("ignore_bcd", cap, 12'h042);

        // Start held high: back-to-back conversions, second bin presented in
        // the done cycle.
        nd = 0;
        t_at[0] = 0; t_at[1] = 0; t_bcd[0] = '0; t_bcd[1] = '0;
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd17;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (done) begin
                if (nd < 2) begin
                    t_at[nd]  = c;
                    t_bcd[nd] = bcd;
                end
                nd++;
            end
            if (c == 9) bin = 8'd128;
            if (nd >= 2) start = 1'b0;
        end
        chk("held_done_count", nd, 2);
        chk("held_first_time", t_at[0], 9);
        chk("held_spacing", t_at[1] - t_at[0], 9);
        chk("held_bcd0", t_bcd[0], 12'h017);
        chk("held_bcd1", t_bcd[1], 12'h128);

        // Reset mid-conversion aborts with no done; bcd clears.
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd123;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_bcd",  bcd,  0);
`ifdef PROD_BCD_BLANK_EN
        chk("abort_blank", blank, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort_no_done", nd, 0);
        chk("abort_idle_busy", busy, 0);
        run_conv(8'd123, "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
